seven_segment_scan_controller: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display with hex decode,
//  per-digit decimal points, 16-level brightness PWM and optional leading-zero blanking.
//  New values are double-buffered and committed only at frame boundaries, so the display

---
 rtl/seven_segment_scan_if.sv | 35 +++
 rtl/seven_segment_scan_controller.sv | 127 ++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_if.sv
// Bus between a register/CPU side (master) and the seven-segment scan
// controller (slave).
//   load        master->slave  1-cycle strobe that captures value/dp/lz_en
//   value       master->slave  hex nibbles, digit i = value[4i+3:4i]
//   dp          master->slave  decimal point per digit, 1 = lit
//   lz_en       master->slave  leading-zero blanking enable
//   brightness  master->slave  anode on-ticks per 16-tick digit slot
//   busy        slave->master  pending buffer not yet committed
//   frame_done  slave->master  1-cycle pulse at end of frame
//   seg/seg_dp  slave->master  segment pins {a..g}, decimal point pin
//   an          slave->master  anode pins
interface seven_segment_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic                      lz_en;
    logic [3:0]                brightness;
    logic                      busy;
    logic                      frame_done;
    logic [6:0]                seg;
    logic                      seg_dp;
    logic [NUM_DIGITS-1:0]     an;

    modport master (
        output load, value, dp, lz_en, brightness,
        input  busy, frame_done, seg, seg_dp, an
    );

    modport slave (
        input  load, value, dp, lz_en, brightness,
        output busy, frame_done, seg, seg_dp, an
    );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed N-digit common-anode 7-segment driver with hex decode,
// per-digit decimal points, 16-level PWM brightness and leading-zero blanking.
// Loads land in a pending buffer and are copied to the active buffer only at
// the end of a frame, so a frame never mixes old and new data.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seven_segment_scan_if.slave (load/value/dp/lz_en/brightness in,
//          busy/frame_done/seg/seg_dp/an out; all outputs registered)
module seven_segment_scan_controller #(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_DIV     = 1024,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_segment_scan_if.slave bus
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Pin-level "off" values after polarity is applied.
    localparam logic [6:0]            SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACT_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACT_LOW ? '1 : '0;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] nib;
        logic [NUM_DIGITS-1:0]      dp;
        logic                       lz;
    } disp_t;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
        endcase
    endfunction

    disp_t                 incoming, pending, active;
    logic [PW-1:0]         prescaler;
    logic [3:0]            sub;
    logic [DW-1:0]         digit;
    logic                  tick, frame_end, lit;
    logic [NUM_DIGITS-1:0] blank, hot;
    logic                  upper_nz;

    logic                  busy_q, frame_done_q, seg_dp_q;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    assign incoming  = {bus.value, bus.dp, bus.lz_en};
    assign tick      = (prescaler == PW'(CLK_DIV - 1));
    assign frame_end = tick && (sub == 4'hF) && (digit == DW'(NUM_DIGITS - 1));
    assign lit       = (sub < bus.brightness);
    assign hot       = NUM_DIGITS'(1) << digit;

    // Walk from the most significant digit down: a digit is a leading zero
    // while every nibble at or above it is zero. Digit 0 always shows.
    always_comb begin
        upper_nz = 1'b0;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_nz = upper_nz | (|active.nib[i]);
            blank[i] = (i != 0) && active.lz && !upper_nz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler    <= '0;
            sub          <= '0;
            digit        <= '0;
            pending      <= '0;
            active       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            seg_dp_q     <= DP_OFF;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                sub <= sub + 1'b1;
                if (sub == 4'hF)
                    digit <= (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + 1'b1;
            end

            frame_done_q <= frame_end;

            // Commit uses the pending value from before this edge, so a load
            // arriving in the commit cycle stays pending for the next frame.
            if (frame_end && busy_q)
                active <= pending;
            if (bus.load) begin
                pending <= incoming;
                busy_q  <= 1'b1;
            end else if (frame_end) begin
                busy_q  <= 1'b0;
            end

            if (lit) begin
                an_q     <= AN_ACT_LOW ? ~hot : hot;
                seg_q    <= blank[digit] ? SEG_OFF
                          : (SEG_ACT_LOW ? ~hex7(active.nib[digit]) : hex7(active.nib[digit]));
                seg_dp_q <= active.dp[digit] ? ~DP_OFF : DP_OFF;
            end else begin
                an_q     <= AN_OFF;
                seg_q    <= SEG_OFF;
                seg_dp_q <= DP_OFF;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.seg_dp     = seg_dp_q;
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: two instances share clock, reset
// and stimulus (4 digits active-low pins, 1 digit active-high pins). A
// reference model derives digit/sub from the cycle count since reset with
// plain arithmetic and tracks the pending/active buffers per instance.
module tb_seven_segment_scan_controller;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        load;
    logic [15:0] val;
    logic [3:0]  dps;
    logic        lz;
    logic [3:0]  bright;

    seven_segment_scan_if #(.NUM_DIGITS(4)) b0 ();
    seven_segment_scan_if #(.NUM_DIGITS(1)) b1 ();

    assign b0.load = load;  assign b0.value = val;      assign b0.dp = dps;
    assign b0.lz_en = lz;   assign b0.brightness = bright;
    assign b1.load = load;  assign b1.value = val[3:0]; assign b1.dp = dps[0];
    assign b1.lz_en = lz;   assign b1.brightness = bright;

    seven_segment_scan_controller #(.NUM_DIGITS(4), .CLK_DIV(CD), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    seven_segment_scan_controller #(.NUM_DIGITS(1), .CLK_DIV(CD), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int total = 0;
    int bad   = 0;

    int   nd [2] = '{4, 1};
    bit   sl [2] = '{1'b1, 1'b0};
    bit   al [2] = '{1'b1, 1'b0};
    logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int          n;
    logic [15:0] act_v [2], pen_v [2];
    logic [3:0]  act_d [2], pen_d [2];
    bit          act_lz [2], pen_lz [2], m_busy [2];
    logic [31:0] exp_w [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // {an(16), seg(7), dp, busy, frame_done} at pin polarity.
    function automatic logic [31:0] pack(input int k, input logic [15:0] an_hi, input logic [6:0] seg_hi,
                                         input logic dp_hi, input logic bsy, input logic fd);
        logic [15:0] m, an;
        logic [6:0]  s;
        logic        d;
        m  = 16'((32'd1 << nd[k]) - 1);
        an = al[k] ? (~an_hi & m) : an_hi;
        s  = sl[k] ? ~seg_hi : seg_hi;
        d  = sl[k] ? ~dp_hi : dp_hi;
        return {an, s, d, bsy, fd};
    endfunction

    task automatic model_reset();
        n = 0;
        for (int k = 0; k < 2; k++) begin
            act_v[k] = '0; pen_v[k] = '0; act_d[k] = '0; pen_d[k] = '0;
            act_lz[k] = 1'b0; pen_lz[k] = 1'b0; m_busy[k] = 1'b0;
        end
    endtask

    // Expected pins after the coming edge come from the state at cycle n.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int f, pos, dig, sb, nib;
            bit on, blk, fd;
            logic [15:0] an_hi;
            logic [6:0]  sh;
            logic        dh;
            f   = nd[k] * 16 * CD;
            pos = n % f;
            dig = pos / (16 * CD);
            sb  = (pos / CD) % 16;
            on  = sb < int'(bright);
            nib = int'((act_v[k] >> (4 * dig)) & 16'hF);
            blk = act_lz[k] && dig > 0 && ((act_v[k] >> (4 * dig)) == 16'h0);
            an_hi = on ? 16'(1 << dig) : 16'h0;
            sh    = (on && !blk) ? hex_tab[nib] : 7'h00;
            dh    = on && act_d[k][dig];
            fd    = (pos == f - 1);
            if (fd && m_busy[k]) begin
                act_v[k] = pen_v[k]; act_d[k] = pen_d[k]; act_lz[k] = pen_lz[k];
            end
            if (load) begin
                pen_v[k]  = val & 16'((32'd1 << (4 * nd[k])) - 1);
                pen_d[k]  = dps & 4'((1 << nd[k]) - 1);
                pen_lz[k] = lz;
                m_busy[k] = 1'b1;
            end else if (fd) begin
                m_busy[k] = 1'b0;
            end
            exp_w[k] = pack(k, an_hi, sh, dh, m_busy[k], fd);
        end
        n++;
    endtask

    task automatic cyc(input bit ld);
        @(negedge clk);
        load = ld;
        @(posedge clk);
        model_edge();
        #1;
        chk("u0_pins", {16'(b0.an), b0.seg, b0.seg_dp, b0.busy, b0.frame_done}, exp_w[0]);
        chk("u1_pins", {16'(b1.an), b1.seg, b1.seg_dp, b1.busy, b1.frame_done}, exp_w[1]);
    endtask

    task automatic reset_check();
        chk("u0_reset", {16'(b0.an), b0.seg, b0.seg_dp, b0.busy, b0.frame_done}, pack(0, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0));
        chk("u1_reset", {16'(b1.an), b1.seg, b1.seg_dp, b1.busy, b1.frame_done}, pack(1, 16'h0, 7'h0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        load = 1'b0; val = '0; dps = '0; lz = 1'b0; bright = 4'd15;
        model_reset();
        #23;
        reset_check();
        @(posedge clk); #2 rst_n = 1'b1;

        // Plain hex display at full brightness.
        val = 16'h12AF; dps = 4'b0000; lz = 1'b0;
        cyc(1'b1);
        repeat (3 * 256 - 1) cyc(1'b0);

        // Dark, then quarter brightness.
        bright = 4'd0;  repeat (256) cyc(1'b0);
        bright = 4'd4;  repeat (256) cyc(1'b0);
        bright = 4'd15;

        // Overwrite while busy, then load exactly in the commit cycle.
        val = 16'h1111; cyc(1'b1);
        repeat (40) cyc(1'b0);
        val = 16'h2222; dps = 4'b0101; cyc(1'b1);
        while (n % 256 != 255) cyc(1'b0);
        val = 16'h3C5A; dps = 4'b0010; cyc(1'b1);
        repeat (600) cyc(1'b0);

        // Leading-zero blanking, including an all-zero value with a dp on a blanked digit.
        lz = 1'b1; val = 16'h0050; dps = 4'b0000; cyc(1'b1);
        repeat (600) cyc(1'b0);
        val = 16'h0000; dps = 4'b1000; cyc(1'b1);
        repeat (600) cyc(1'b0);

        // Random loads and live brightness changes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) bright = 4'($urandom_range(15));
            if ($urandom_range(99) == 0) begin
                val = 16'($urandom); dps = 4'($urandom); lz = 1'($urandom);
                cyc(1'b1);
            end else begin
                cyc(1'b0);
            end
        end

        // Reset mid-slot with a pending load outstanding.
        bright = 4'd15; lz = 1'b0;
        while (n % 256 != 10) cyc(1'b0);
        val = 16'hBEEF; dps = 4'b0001; cyc(1'b1);
        repeat (37) cyc(1'b0);
        @(negedge clk);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1 reset_check();
        model_reset();
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        repeat (600) cyc(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
